// File: rtl/inst_encoder_loader.sv
// Instruction encoder / program loader: buffers decoded fields in a small FIFO, encodes RV32I words
// and writes them to consecutive imem addresses from BASE_ADDR. Define ENC_JAL_EN to enable jal encoding.
module inst_encoder_loader #(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_1000,
  parameter int          MAX_WORDS  = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_kind,
  input  logic [2:0]  in_alu,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [20:0] in_imm,
  input  logic        in_last,
  output logic        imem_we,
  input  logic        imem_ready,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        done,
  output logic        err,
  output logic [8:0]  word_count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [1:0] S_RUN = 2'd0, S_CLOSING = 2'd1, S_DONE = 2'd2;

  typedef struct packed {
    logic [2:0]  kind;
    logic [2:0]  alu;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [20:0] imm;
  } ent_t;

  ent_t          mem [FIFO_DEPTH];
  ent_t          in_ent, head;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   cnt;
  logic [1:0]    state;
  logic          fifo_full, fifo_empty, push, pop, wr_fire, hit_max;
  logic          head_ok, alu_ok, imm12_ok, imm13_ok;
  logic [31:0]   head_enc;
  logic [2:0]    f3;
  logic [6:0]    f7;

  assign in_ent     = {in_kind, in_alu, in_rd, in_rs1, in_rs2, in_imm};
  assign fifo_full  = (cnt == (AW+1)'(FIFO_DEPTH));
  assign fifo_empty = (cnt == '0);
  assign in_ready   = !rst && !fifo_full && (state == S_RUN);
  assign push       = in_valid && in_ready;
  assign wr_fire    = imem_we && imem_ready;
  assign hit_max    = wr_fire && (word_count == 9'(MAX_WORDS - 1));
  // Output register frees when idle or completing; the capping write blocks any further load.
  assign pop        = !fifo_empty && (!imem_we || imem_ready) && (state != S_DONE) && !hit_max;
  assign done       = (state == S_DONE);
  assign head       = mem[rd_ptr];

  always_comb begin
    f3       = 3'b000;
    f7       = 7'b0000000;
    alu_ok   = 1'b1;
    case (head.alu)
      3'd0: ;
      3'd1: f7 = 7'b0100000;
      3'd2: f3 = 3'b010;
      3'd3: f3 = 3'b110;
      3'd4: f3 = 3'b111;
      default: alu_ok = 1'b0;
    endcase
    imm12_ok = (&head.imm[20:11]) || !(|head.imm[20:11]);
    imm13_ok = (&head.imm[20:12]) || !(|head.imm[20:12]);
    head_ok  = 1'b0;
    head_enc = '0;
    case (head.kind)
      3'd0: begin
        head_ok  = imm12_ok;
        head_enc = {head.imm[11:0], head.rs1, 3'b010, head.rd, 7'b0000011};
      end
      3'd1: begin
        head_ok  = imm12_ok;
        head_enc = {head.imm[11:5], head.rs2, head.rs1, 3'b010, head.imm[4:0], 7'b0100011};
      end
      3'd2: begin
        head_ok  = alu_ok;
        head_enc = {f7, head.rs2, head.rs1, f3, head.rd, 7'b0110011};
      end
      3'd3: begin
        head_ok  = imm13_ok && !head.imm[0];
        head_enc = {head.imm[12], head.imm[10:5], head.rs2, head.rs1, 3'b000,
                    head.imm[4:1], head.imm[11], 7'b1100011};
      end
      3'd4: begin
        head_ok  = alu_ok && (head.alu != 3'd1) && imm12_ok;
        head_enc = {head.imm[11:0], head.rs1, f3, head.rd, 7'b0010011};
      end
`ifdef ENC_JAL_EN
      3'd5: begin
        head_ok  = !head.imm[0];
        head_enc = {head.imm[20], head.imm[10:1], head.imm[11], head.imm[19:12], head.rd, 7'b1101111};
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_ent;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      cnt        <= '0;
      state      <= S_RUN;
      imem_we    <= 1'b0;
      imem_addr  <= BASE_ADDR;
      imem_wdata <= '0;
      err        <= 1'b0;
      word_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
      if (wr_fire) begin
        imem_addr  <= imem_addr + 32'd4;
        word_count <= word_count + 9'd1;
        imem_we    <= 1'b0;
      end
      // A dropped entry leaves the output register empty for this pop cycle.
      if (pop) begin
        if (head_ok) begin
          imem_we    <= 1'b1;
          imem_wdata <= head_enc;
        end else begin
          err <= 1'b1;
        end
      end
      case (state)
        S_RUN:     if (push && in_last) state <= S_CLOSING;
        S_CLOSING: if (fifo_empty && !imem_we) state <= S_DONE;
        default: ;
      endcase
      if (hit_max) begin
        state  <= S_DONE;
        wr_ptr <= '0;
        rd_ptr <= '0;
        cnt    <= '0;
        if (!fifo_empty || push) err <= 1'b1;
      end
    end
  end
endmodule

// File: doc/inst_encoder_loader.md
# inst_encoder_loader

Sequential instruction encoder and program loader for the single-cycle RISC-V core: accepts decoded instruction fields over a valid/ready stream, encodes them into 32-bit RV32I words, and writes them to consecutive instruction-memory addresses starting at the core reset PC. It is the inverse of the core's control-unit decode path. It covers lw, sw, R-type and I-type ALU ops (add, sub, slt, or, and), beq and jal. A small FIFO decouples the producer from instruction-memory backpressure.

## Interface
- FIFO_DEPTH, 4, entries buffered between input handshake and memory write (power of 2, ≥2)
- BASE_ADDR, 32'h0000_1000, address of first written word (matches core reset PC)
- MAX_WORDS, 256, maximum words written before the block closes

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  producer has an entry
- in_ready  out  1  block accepts the entry this cycle
- in_kind  in  3  0 lw, 1 sw, 2 R-type, 3 beq, 4 I-ALU, 5 jal, 6–7 illegal
- in_alu  in  3  0 add, 1 sub, 2 slt, 3 or, 4 and; used for kinds 2 and 4
- in_rd, in_rs1, in_rs2  in  5 each  register fields
- in_imm  in  21  signed immediate / byte offset
- in_last  in  1  final entry of the program
- imem_we  out  1  write request
- imem_ready  in  1  memory accepts the write this cycle
- imem_addr  out  32  word byte address
- imem_wdata  out  32  encoded instruction
- done  out  1  program closed (sticky until rst)
- err  out  1  sticky: at least one entry dropped
- word_count  out  9  words written so far

## Operation
- Accept: an entry is pushed at an edge where in_valid & in_ready. in_ready = !rst & !fifo_full & state==RUN.
- Encoding (standard RV32I): lw imm[11:0]|rs1|010|rd|0000011; sw imm[11:5]|rs2|rs1|010|imm[4:0]|0100011; R funct7|rs2|rs1|funct3|rd|0110011 with add 000/0000000, sub 000/0100000, slt 010, or 110, and 111 (funct7 0); I-ALU imm[11:0]|rs1|funct3|rd|0010011; beq imm[12|10:5]|rs2|rs1|000|imm[4:1|11]|1100011; jal imm[20|10:1|11|19:12]|rd|1101111.
- Drop rules (entry consumed, no write, err set, address not advanced): kind 6/7; in_alu > 4; I-ALU with sub; lw/sw/I-ALU imm outside signed 12-bit; beq imm outside signed 13-bit or imm[0]=1; jal imm[0]=1.
- States: RUN (accepting/writing) → CLOSING once in_last is accepted (in_ready low) → DONE when the FIFO is drained and the last write is accepted. A dropped in_last entry still closes. DONE is also entered when word_count reaches MAX_WORDS; FIFO contents are then discarded and err is set if any were pending. DONE holds until rst.
- Write stage: a single output register. When it is empty or its write is accepted, and the FIFO is non-empty, the FIFO head is popped, encoded and loaded.

## Timing
- Reset (edge with rst=1): FIFO empty, state RUN, imem_we 0, imem_addr BASE_ADDR, imem_wdata 0, done 0, err 0, word_count 0. in_ready is 0 while rst is high. Reset mid-write abandons the write.
- Latency: an entry pushed at edge k into an empty FIFO with the write stage idle gives imem_we=1 after edge k+1.
- A write completes at an edge with imem_we & imem_ready. imem_addr then increments by 4 and word_count by 1. A back-to-back pop in the same edge is allowed (1 word/cycle sustained).
- While imem_we & !imem_ready: imem_addr and imem_wdata are held stable and the FIFO keeps filling. in_ready drops once FIFO_DEPTH entries are held. There is no push pass-through when full.
- A dropped entry costs one pop cycle with imem_we=0.
- done rises at the edge after the final write completes, or in the same edge word_count reaches MAX_WORDS.

## Configuration
- ENC_JAL_EN: when defined, kind 5 encodes jal as above. When undefined, kind 5 is illegal (dropped, err set), and the jal encoder and offset check are removed.

## Test plan
- lw x5,8(x2) (kind 0, rd 5, rs1 2, imm 8), imem_ready=1 -> one write, addr 0x00001000, data 0x00812283, word_count 1.
- sub x3,x1,x2 then beq x1,x2,-4 (in_last) -> data 0x402081B3 @0x1000, then 0xFE208EE3 @0x1004, then done=1.
- jal x1,16 with ENC_JAL_EN defined -> data 0x010000EF. Without the macro -> no write, err=1.
- Illegal entries: lw imm=2048, I-ALU sub, and beq imm=3, each followed by a valid add x1,x0,x0 -> three drops, err=1, the single write 0x000000B3 lands @0x1000.
- imem_ready=0 for 10 cycles while pushing 6 entries -> in_ready low after 4 FIFO entries plus 1 in the write register, addr/data stable. Release -> 5 writes on consecutive cycles in order, then the 6th is accepted.
- Assert rst for one cycle mid-stream with 3 entries pending -> imem_we=0, addr 0x1000, word_count 0, err 0 next cycle. New entries write from 0x1000.
